// File: rtl/qc_sched_pkg.sv
// Shared types and helpers for the qubit scheduler slice.
// Link arbiter state encoding and qubit-to-FPGA mapping live here.
package qc_sched_pkg;

  localparam int NUM_FPGA = 64;
  localparam int NUM_QUBIT_PER_FPGA = 64;
  localparam int QW = $clog2(NUM_FPGA * NUM_QUBIT_PER_FPGA);
  localparam int FW = $clog2(NUM_FPGA);

  typedef struct packed {
    logic [QW-1:0] qa;
    logic [QW-1:0] qb;
  } gate_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } link_state_e;

  function automatic logic [FW-1:0] fpga_of(
    input logic [QW-1:0] idx
  );
    return FW'(idx / QW'(NUM_QUBIT_PER_FPGA));
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit at or after ptr,
// searching upward and wrapping; N need not be a power of two.
module rr_pick #(
  parameter int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] onehot,
  output logic [W-1:0] idx,
  output logic         any
);

  int j;

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/link_arbiter.sv
// Shares the single inter-FPGA link among scheduler issue lanes.
// Local gates bypass; remote gates win the link round-robin.
module link_arbiter
  import qc_sched_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int NUM_FPGA           = 64,
  parameter int NUM_QUBIT_PER_FPGA = 64,
  parameter int LINK_CYCLES        = 8,
  localparam int QW = $clog2(NUM_FPGA * NUM_QUBIT_PER_FPGA),
  localparam int FW = $clog2(NUM_FPGA),
  localparam int RW = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ-1:0][QW-1:0]   req_qa,
  input  logic [NUM_REQ-1:0][QW-1:0]   req_qb,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         link_valid,
  output logic [FW-1:0]                link_src,
  output logic [FW-1:0]                link_dst,
  output logic [RW-1:0]                link_owner,
  output logic                         link_done,
  output logic [15:0]                  grant_cnt
);

  localparam int CW = (LINK_CYCLES > 1) ? $clog2(LINK_CYCLES) : 1;

  logic [NUM_REQ-1:0][FW-1:0] fa;
  logic [NUM_REQ-1:0][FW-1:0] fb;
  logic [NUM_REQ-1:0]         is_local;
  logic [NUM_REQ-1:0]         remote_v;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      fa[i]       = FW'(req_qa[i] / QW'(NUM_QUBIT_PER_FPGA));
      fb[i]       = FW'(req_qb[i] / QW'(NUM_QUBIT_PER_FPGA));
      is_local[i] = (fa[i] == fb[i]);
    end
    remote_v = req_valid & ~is_local;
  end

  link_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rr_ptr_q, rr_ptr_d;
  logic [FW-1:0] src_q, src_d;
  logic [FW-1:0] dst_q, dst_d;
  logic [RW-1:0] owner_q, owner_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [15:0]   gcnt_q, gcnt_d;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [RW-1:0]      pick_idx;
  logic               pick_any;

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req    (remote_v),
    .ptr    (rr_ptr_q),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  logic grant_win;
  logic accept;

  always_comb begin
    grant_win = (state_q == ST_IDLE) || (cnt_q == '0);
    accept    = grant_win && pick_any && !rst;
    req_ready = '0;
    if (!rst) begin
      req_ready = (req_valid & is_local)
                | (accept ? pick_onehot : '0);
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    src_d    = src_q;
    dst_d    = dst_q;
    owner_d  = owner_q;
    gcnt_d   = gcnt_q;
    if (accept) begin
      state_d  = ST_BUSY;
      cnt_d    = CW'(LINK_CYCLES - 1);
      src_d    = fa[pick_idx];
      dst_d    = fb[pick_idx];
      owner_d  = pick_idx;
      gcnt_d   = gcnt_q + 16'd1;
      rr_ptr_d = (pick_idx == RW'(NUM_REQ - 1))
               ? '0 : pick_idx + RW'(1);
    end else if (state_q == ST_BUSY) begin
      if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
      else state_d = ST_IDLE;
    end
    // outputs registered from next-state so they align with state_q
    valid_d = (state_d == ST_BUSY);
    done_d  = (state_d == ST_BUSY) && (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= '0;
      src_q    <= '0;
      dst_q    <= '0;
      owner_q  <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
      gcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      owner_q  <= owner_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
      gcnt_q   <= gcnt_d;
    end
  end

  assign link_valid = valid_q;
  assign link_done  = done_q;
  assign link_src   = src_q;
  assign link_dst   = dst_q;
  assign link_owner = owner_q;
  assign grant_cnt  = gcnt_q;

endmodule

// File: tb/tb_link_arbiter.sv
// Directed bench for link_arbiter: main 4-lane/8-cycle instance plus
// 3-lane and 1-cycle-link instances; owner order checked by scoreboard.
module tb_link_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance: NUM_REQ=4, LINK_CYCLES=8
  logic [3:0]        v0;
  logic [3:0][11:0]  qa0, qb0;
  logic [3:0]        rdy0;
  logic              lv0, ld0;
  logic [5:0]        src0, dst0;
  logic [1:0]        own0;
  logic [15:0]       gc0;

  link_arbiter u0 (
    .clk(clk), .rst(rst), .req_valid(v0), .req_qa(qa0), .req_qb(qb0),
    .req_ready(rdy0), .link_valid(lv0), .link_src(src0),
    .link_dst(dst0), .link_owner(own0), .link_done(ld0),
    .grant_cnt(gc0)
  );

  // NUM_REQ=3 instance
  logic [2:0]        v3;
  logic [2:0][11:0]  qa3, qb3;
  logic [2:0]        rdy3;
  logic              lv3, ld3;
  logic [5:0]        src3, dst3;
  logic [1:0]        own3;
  logic [15:0]       gc3;

  link_arbiter #(.NUM_REQ(3)) u3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_qa(qa3), .req_qb(qb3),
    .req_ready(rdy3), .link_valid(lv3), .link_src(src3),
    .link_dst(dst3), .link_owner(own3), .link_done(ld3),
    .grant_cnt(gc3)
  );

  // LINK_CYCLES=1 instance
  logic [3:0]        v1;
  logic [3:0][11:0]  qa1, qb1;
  logic [3:0]        rdy1;
  logic              lv1, ld1;
  logic [5:0]        src1, dst1;
  logic [1:0]        own1;
  logic [15:0]       gc1;

  link_arbiter #(.LINK_CYCLES(1)) u1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_qa(qa1), .req_qb(qb1),
    .req_ready(rdy1), .link_valid(lv1), .link_src(src1),
    .link_dst(dst1), .link_owner(own1), .link_done(ld1),
    .grant_cnt(gc1)
  );

  int vecs = 0;
  int errs = 0;
  int sb[$];
  logic pv, pd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [31:0] obs);
    int e;
    if (sb.size() == 0) begin
      vecs++;
      errs++;
      $error("FAIL %s observed=%0h expected=<no entry>", tag, obs);
    end else begin
      e = sb.pop_front();
      chk(tag, obs, 32'(e));
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    v0 = '0; v3 = '0; v1 = '0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    v3 = '0; v1 = '0;
    qa3 = '0; qb3 = '0; qa1 = '0; qb1 = '0;
    v0 = 4'hF;
    for (int i = 0; i < 4; i++) begin
      qa0[i] = 12'(i * 64);
      qb0[i] = 12'((20 + i) * 64 + 3);
    end

    // reset held 2 cycles with all lanes offering
    repeat (2) begin
      @(negedge clk);
      chk("rst_ready", 32'(rdy0), 0);
    end
    chk("rst_valid", 32'(lv0), 0);
    chk("rst_done", 32'(ld0), 0);
    chk("rst_gcnt", 32'(gc0), 0);
    chk("rst_owner", 32'(own0), 0);
    chk("rst_src", 32'(src0), 0);

    // single remote on lane 2
    @(posedge clk); #1;
    rst = 1'b0;
    v0 = 4'b0100;
    qa0[2] = 12'h041;
    qb0[2] = 12'h0C5;
    @(negedge clk);
    chk("single_ready", 32'(rdy0), 32'h4);
    chk("single_pre_valid", 32'(lv0), 0);
    @(posedge clk); #1;
    v0 = '0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("single_valid", 32'(lv0), 1);
      chk("single_src", 32'(src0), 1);
      chk("single_dst", 32'(dst0), 3);
      chk("single_owner", 32'(own0), 2);
      chk("single_done", 32'(ld0), (k == 7) ? 1 : 0);
    end
    @(negedge clk);
    chk("single_after_valid", 32'(lv0), 0);
    chk("single_after_done", 32'(ld0), 0);
    chk("single_gcnt", 32'(gc0), 1);

    // fairness: all four remote and held
    do_reset();
    for (int i = 0; i < 4; i++) begin
      qa0[i] = 12'(i * 64);
      qb0[i] = 12'((20 + i) * 64 + 3);
    end
    v0 = 4'hF;
    sb.push_back(0); sb.push_back(1); sb.push_back(2);
    sb.push_back(3); sb.push_back(0);
    @(negedge clk);
    chk("fair_first_ready", 32'(rdy0), 32'h1);
    pv = 1'b0;
    pd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("fair_valid", 32'(lv0), 1);
      if (lv0 && (!pv || pd)) pop_cmp("fair_owner", 32'(own0));
      pv = lv0;
      pd = ld0;
    end
    chk("fair_gcnt", 32'(gc0), 5);
    chk("fair_sb_empty", 32'(sb.size()), 0);

    // local bypass while lane 0 owns the link
    do_reset();
    qa0[0] = 12'h0C0;
    qb0[0] = 12'h400;
    v0 = 4'b0001;
    @(negedge clk);
    chk("bypass_grant_ready", 32'(rdy0), 32'h1);
    @(posedge clk); #1;
    v0 = '0;
    @(posedge clk); #1;
    qa0[1] = 12'h080;
    qb0[1] = 12'h0BF;
    v0 = 4'b0010;
    @(negedge clk);
    chk("bypass_ready", 32'(rdy0), 32'h2);
    chk("bypass_valid", 32'(lv0), 1);
    chk("bypass_owner", 32'(own0), 0);
    @(posedge clk); #1;
    v0 = '0;
    @(negedge clk);
    chk("bypass_gcnt", 32'(gc0), 1);
    chk("bypass_owner_kept", 32'(own0), 0);
    chk("bypass_src", 32'(src0), 3);
    chk("bypass_dst", 32'(dst0), 16);
    chk("bypass_valid_kept", 32'(lv0), 1);

    // reset mid-transfer, request held throughout
    do_reset();
    qa0[0] = 12'h0C0;
    qb0[0] = 12'h400;
    v0 = 4'b0001;
    @(negedge clk);
    chk("mid_first_ready", 32'(rdy0), 32'h1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("mid_valid", 32'(lv0), 1);
      chk("mid_busy_ready", 32'(rdy0), 0);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(rdy0), 0);
    chk("mid_rst_valid", 32'(lv0), 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_abort_valid", 32'(lv0), 0);
    chk("mid_abort_done", 32'(ld0), 0);
    chk("mid_abort_gcnt", 32'(gc0), 0);
    chk("mid_regrant_ready", 32'(rdy0), 32'h1);
    @(negedge clk);
    chk("mid_regrant_valid", 32'(lv0), 1);
    chk("mid_regrant_owner", 32'(own0), 0);
    chk("mid_regrant_gcnt", 32'(gc0), 1);

    // NUM_REQ=3: owner order 0,1,2,0
    do_reset();
    for (int i = 0; i < 3; i++) begin
      qa3[i] = 12'((i + 1) * 64 + 7);
      qb3[i] = 12'((40 + i) * 64);
    end
    v3 = 3'b111;
    sb.push_back(0); sb.push_back(1);
    sb.push_back(2); sb.push_back(0);
    @(negedge clk);
    chk("n3_first_ready", 32'(rdy3), 32'h1);
    pv = 1'b0;
    pd = 1'b0;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      chk("n3_valid", 32'(lv3), 1);
      if (lv3 && (!pv || pd)) pop_cmp("n3_owner", 32'(own3));
      pv = lv3;
      pd = ld3;
    end
    chk("n3_sb_empty", 32'(sb.size()), 0);

    // LINK_CYCLES=1: owner alternates, done every cycle
    do_reset();
    for (int i = 0; i < 4; i++) begin
      qa1[i] = 12'(i * 64 + 1);
      qb1[i] = 12'((50 + i) * 64 + 2);
    end
    v1 = 4'b0011;
    for (int k = 0; k < 6; k++) sb.push_back(k % 2);
    @(negedge clk);
    chk("lc1_first_ready", 32'(rdy1), 32'h1);
    pv = 1'b0;
    pd = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk("lc1_valid", 32'(lv1), 1);
      chk("lc1_done", 32'(ld1), 1);
      if (lv1 && (!pv || pd)) pop_cmp("lc1_owner", 32'(own1));
      pv = lv1;
      pd = ld1;
    end
    chk("lc1_gcnt", 32'(gc1), 6);
    chk("lc1_sb_empty", 32'(sb.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
